wb_lsu: RTL

Parametrised load/store unit that turns RV32I load and store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into Wishbone classic master cycles. It sits between the `cpu` execute stage and the shared Wishbone data bus. Misaligned accesses that cross a word boundary are split into two bus phases, RTY responses trigger a bounded retry, and stalled cycles are aborted by a timeout. Every request gets exactly one response, carrying either read data or an error status.

---
 rtl/wb_lsu_if.sv | 41 ++++
 rtl/wb_lsu.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_lsu_if.sv
// wb_lsu_if: bundles the load/store unit's CPU-side request/response handshake and its
// Wishbone classic master bus.
//   modport master : the load/store unit (drives req_ready, resp_*, cyc/stb/we/adr/sel/dat_o)
//   modport slave  : the environment, i.e. the CPU stage plus the Wishbone slave
//                    (drives req_*, dat_i, ack_i/err_i/rty_i)
interface wb_lsu_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [2:0]  req_funct3_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic        resp_misaligned_o;
   logic        cyc_o;
   logic        stb_o;
   logic        we_o;
   logic [31:0] adr_o;
   logic [3:0]  sel_o;
   logic [31:0] dat_o;
   logic [31:0] dat_i;
   logic        ack_i;
   logic        err_i;
   logic        rty_i;

   modport master (
      input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
      input  dat_i, ack_i, err_i, rty_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, resp_misaligned_o,
      output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o
   );

   modport slave (
      output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
      output dat_i, ack_i, err_i, rty_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, resp_misaligned_o,
      input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o
   );
endinterface

// File: rtl/wb_lsu.sv
// wb_lsu: RV32I load/store unit driving a Wishbone classic master. Word-crossing accesses
// are split into two bus phases, RTY is retried a bounded number of times per phase, and a
// stalled phase is aborted after TIMEOUT_CYCLES. Each accepted request yields exactly one
// resp_valid_o pulse.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : wb_lsu_if.master - request/response handshake and Wishbone master signals;
//            all Wishbone outputs and response outputs are registered
module wb_lsu #(
   parameter int unsigned TIMEOUT_CYCLES     = 255,
   parameter int unsigned MAX_RETRIES        = 3,
   parameter bit          SUPPORT_MISALIGNED = 1'b1
) (
   input logic      clk_i,
   input logic      rst_i,
   wb_lsu_if.master bus
);

   typedef enum logic [2:0] {StIdle, StPh0, StPh1, StRetry, StResp} state_e;

   localparam logic [31:0] TmoLast    = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] MaxRetries = 32'(MAX_RETRIES);

   state_e      state_q, state_d;
   logic        ret_ph1_q, ret_ph1_d;  // phase to re-enter after RETRY
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic [3:0]  hi_q, hi_d;           // byte lanes of the second word
   logic        cross_q, cross_d;
   logic [31:0] wd_hi_q, wd_hi_d;     // store data for the second word
   logic [31:0] word0_q, word0_d;     // first-word load data of a split access
   logic [31:0] retry_q, retry_d;
   logic [31:0] tmo_q, tmo_d;
   logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
   logic [31:0] adr_q, adr_d, dat_q, dat_d, rdata_q, rdata_d;
   logic [3:0]  sel_q, sel_d;
   logic        rv_q, rv_d, err_q, err_d, mis_q, mis_d;

   logic [3:0]  size_mask;
   logic [7:0]  mask8;
   logic [63:0] wd64;
   logic        legal;
   logic        finish, fail;

   // Shift the word pair right by the byte offset, then truncate and extend to the size.
   function automatic logic [31:0] load_ext(input logic [63:0] pair, input logic [1:0] off,
                                            input logic [2:0] f3);
      logic [31:0] sh;
      sh = 32'(pair >> {off, 3'b000});
      case (f3[1:0])
         2'b00:   load_ext = {{24{sh[7] & ~f3[2]}}, sh[7:0]};
         2'b01:   load_ext = {{16{sh[15] & ~f3[2]}}, sh[15:0]};
         default: load_ext = sh;
      endcase
   endfunction

   always_comb begin
      state_d   = state_q;
      ret_ph1_d = ret_ph1_q;
      f3_d      = f3_q;
      off_d     = off_q;
      hi_d      = hi_q;
      cross_d   = cross_q;
      wd_hi_d   = wd_hi_q;
      word0_d   = word0_q;
      retry_d   = retry_q;
      tmo_d     = tmo_q;
      cyc_d     = cyc_q;
      stb_d     = stb_q;
      we_d      = we_q;
      adr_d     = adr_q;
      sel_d     = sel_q;
      dat_d     = dat_q;
      rv_d      = rv_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      mis_d     = mis_q;
      finish    = 1'b0;
      fail      = 1'b0;

      case (bus.req_funct3_i[1:0])
         2'b00:   size_mask = 4'b0001;
         2'b01:   size_mask = 4'b0011;
         default: size_mask = 4'b1111;
      endcase
      mask8 = {4'b0000, size_mask} << bus.req_addr_i[1:0];
      wd64  = {32'h0, bus.req_wdata_i} << {bus.req_addr_i[1:0], 3'b000};
      if (bus.req_we_i) legal = ~bus.req_funct3_i[2] & (bus.req_funct3_i[1:0] != 2'b11);
      else              legal = (bus.req_funct3_i[1:0] != 2'b11) &
                                ~(bus.req_funct3_i[2] & bus.req_funct3_i[1]);

      unique case (state_q)
         StIdle: begin
            if (bus.req_valid_i) begin
               f3_d    = bus.req_funct3_i;
               off_d   = bus.req_addr_i[1:0];
               hi_d    = mask8[7:4];
               cross_d = |mask8[7:4];
               wd_hi_d = wd64[63:32];
               we_d    = bus.req_we_i;
               adr_d   = {bus.req_addr_i[31:2], 2'b00};
               sel_d   = mask8[3:0];
               dat_d   = wd64[31:0];
               retry_d = '0;
               tmo_d   = '0;
               if (!legal) begin
                  finish = 1'b1;
                  fail   = 1'b1;
               end else if ((|mask8[7:4]) && !SUPPORT_MISALIGNED) begin
                  finish = 1'b1;
                  fail   = 1'b1;
                  mis_d  = 1'b1;
               end else begin
                  state_d = StPh0;
                  cyc_d   = 1'b1;
                  stb_d   = 1'b1;
               end
            end
         end
         StPh0, StPh1: begin
            if (bus.err_i) begin
               finish = 1'b1;
               fail   = 1'b1;
            end else if (bus.ack_i) begin
               if (state_q == StPh0 && cross_q) begin
                  // Bus stays owned; address, lanes and data move to the second word.
                  state_d = StPh1;
                  word0_d = bus.dat_i;
                  adr_d   = adr_q + 32'd4;
                  sel_d   = hi_q;
                  dat_d   = wd_hi_q;
                  retry_d = '0;
                  tmo_d   = '0;
               end else begin
                  finish  = 1'b1;
                  rdata_d = we_q ? 32'h0 :
                            load_ext((state_q == StPh1) ? {bus.dat_i, word0_q} : {32'h0, bus.dat_i},
                                     off_q, f3_q);
               end
            end else if (bus.rty_i) begin
               if (retry_q == MaxRetries) begin
                  finish = 1'b1;
                  fail   = 1'b1;
               end else begin
                  state_d   = StRetry;
                  ret_ph1_d = (state_q == StPh1);
                  retry_d   = retry_q + 32'd1;
                  tmo_d     = '0;
                  cyc_d     = 1'b0;
                  stb_d     = 1'b0;
               end
            end else if (TIMEOUT_CYCLES != 0 && tmo_q == TmoLast) begin
               finish = 1'b1;
               fail   = 1'b1;
            end else begin
               tmo_d = tmo_q + 32'd1;
            end
         end
         StRetry: begin
            state_d = ret_ph1_q ? StPh1 : StPh0;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            tmo_d   = '0;
         end
         StResp: begin
            state_d = StIdle;
            rv_d    = 1'b0;
            err_d   = 1'b0;
            mis_d   = 1'b0;
            rdata_d = '0;
         end
         default: state_d = StIdle;
      endcase

      if (finish) begin
         state_d = StResp;
         cyc_d   = 1'b0;
         stb_d   = 1'b0;
         we_d    = 1'b0;
         rv_d    = 1'b1;
         err_d   = fail;
         if (fail) rdata_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         ret_ph1_q <= 1'b0;
         f3_q      <= '0;
         off_q     <= '0;
         hi_q      <= '0;
         cross_q   <= 1'b0;
         wd_hi_q   <= '0;
         word0_q   <= '0;
         retry_q   <= '0;
         tmo_q     <= '0;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         sel_q     <= '0;
         dat_q     <= '0;
         rv_q      <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         mis_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ret_ph1_q <= ret_ph1_d;
         f3_q      <= f3_d;
         off_q     <= off_d;
         hi_q      <= hi_d;
         cross_q   <= cross_d;
         wd_hi_q   <= wd_hi_d;
         word0_q   <= word0_d;
         retry_q   <= retry_d;
         tmo_q     <= tmo_d;
         cyc_q     <= cyc_d;
         stb_q     <= stb_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         sel_q     <= sel_d;
         dat_q     <= dat_d;
         rv_q      <= rv_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         mis_q     <= mis_d;
      end
   end

   assign bus.req_ready_o       = (state_q == StIdle);
   assign bus.resp_valid_o      = rv_q;
   assign bus.resp_rdata_o      = rdata_q;
   assign bus.resp_err_o        = err_q;
   assign bus.resp_misaligned_o = mis_q;
   assign bus.cyc_o             = cyc_q;
   assign bus.stb_o             = stb_q;
   assign bus.we_o              = we_q;
   assign bus.adr_o             = adr_q;
   assign bus.sel_o             = sel_q;
   assign bus.dat_o             = dat_q;

endmodule
